// File: rtl/node_port_mux_pkg.sv
// Shared types and direction codes for the node neighbour-port multiplexer.
package node_port_mux_pkg;

    localparam int WORD_BITS = 11;

    typedef logic [WORD_BITS-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        RECV
    } portmux_state_t;

    // Pseudo-directions sit just above the physical port indices.
    function automatic int dir_any(input int nports);
        return nports;
    endfunction

    function automatic int dir_last(input int nports);
        return nports + 1;
    endfunction

    function automatic int dir_nil(input int nports);
        return nports + 2;
    endfunction

endpackage

// File: rtl/node_port_mux_prio_sel.sv
// Lowest-index one-hot grant over a request vector.
module node_port_mux_prio_sel #(
    parameter int N = 4
) (
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);

    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req_i[i] && !found) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/node_port_mux.sv
// Blocking one-word transfers between the node core and its neighbour ports,
// with ANY/LAST/NIL pseudo-directions and abort on halt.
import node_port_mux_pkg::*;

module node_port_mux #(
    parameter int NPORTS = 4,
    parameter int WORD_W = 11,
    parameter int DIR_W  = $clog2(NPORTS + 3)
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     tx,
    input  logic                     rx,
    input  logic [DIR_W-1:0]         dir,
    input  logic                     halt,
    input  logic [WORD_W-1:0]        out_data,
    output logic [WORD_W-1:0]        in_data,
    output logic                     tx_complete,
    output logic                     rx_complete,
    output logic                     busy,
    output logic [DIR_W-1:0]         last_dir,
    output logic [NPORTS-1:0]        port_out_valid,
    output logic [NPORTS*WORD_W-1:0] port_out_data,
    input  logic [NPORTS-1:0]        port_out_ack,
    input  logic [NPORTS-1:0]        port_in_valid,
    input  logic [NPORTS*WORD_W-1:0] port_in_data,
    output logic [NPORTS-1:0]        port_in_ack
);

    localparam logic [DIR_W-1:0] D_ANY  = DIR_W'(dir_any(NPORTS));
    localparam logic [DIR_W-1:0] D_LAST = DIR_W'(dir_last(NPORTS));
    localparam logic [DIR_W-1:0] D_MAXP = DIR_W'(NPORTS - 1);

    portmux_state_t state_q, state_d;

    logic [WORD_W-1:0] data_q, data_d;
    logic [WORD_W-1:0] in_data_q, in_data_d;
    logic              txc_q, txc_d;
    logic              rxc_q, rxc_d;
    logic              any_q, any_d;
    logic              last_valid_q, last_valid_d;
    logic [DIR_W-1:0]  tgt_q, tgt_d;
    logic [DIR_W-1:0]  last_dir_q, last_dir_d;
    logic [DIR_W-1:0]  rr_q, rr_d;
    logic [NPORTS-1:0] ovalid_q, ovalid_d;

    logic [NPORTS-1:0] any_gnt;
    logic [NPORTS-1:0] rx_sel;
    logic [WORD_W-1:0] rx_word;
    logic [DIR_W-1:0]  req_tgt;
    logic              req_any;
    logic              req_nil;
    logic              tx_hit;
    logic              rx_hit;

    function automatic logic [NPORTS-1:0] onehot(input logic [DIR_W-1:0] d);
        logic [NPORTS-1:0] v;
        v = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (DIR_W'(i) == d) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [DIR_W-1:0] idx_of(input logic [NPORTS-1:0] v);
        logic [DIR_W-1:0] r;
        r = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (v[i]) r = DIR_W'(i);
        end
        return r;
    endfunction

    function automatic logic [DIR_W-1:0] rr_next(input logic [DIR_W-1:0] p);
        return (p == D_MAXP) ? '0 : p + 1'b1;
    endfunction

    node_port_mux_prio_sel #(
        .N(NPORTS)
    ) u_prio_sel (
        .req_i(port_in_valid),
        .gnt_o(any_gnt)
    );

    // LAST with no prior ANY, NIL and unused codes all complete immediately.
    assign req_any = (dir == D_ANY);
    assign req_tgt = (dir == D_LAST) ? last_dir_q : dir;
    assign req_nil = (dir > D_LAST) || ((dir == D_LAST) && !last_valid_q);

    assign rx_sel      = any_q ? any_gnt : (onehot(tgt_q) & port_in_valid);
    assign port_in_ack = (state_q == RECV) ? rx_sel : '0;
    assign rx_hit      = |port_in_ack;
    assign tx_hit      = |(ovalid_q & port_out_ack);

    always_comb begin
        rx_word = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (rx_sel[i]) rx_word = port_in_data[i*WORD_W +: WORD_W];
        end
    end

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        in_data_d    = in_data_q;
        txc_d        = 1'b0;
        rxc_d        = 1'b0;
        any_d        = any_q;
        tgt_d        = tgt_q;
        last_dir_d   = last_dir_q;
        last_valid_d = last_valid_q;
        rr_d         = rr_q;
        ovalid_d     = ovalid_q;
        unique case (state_q)
            IDLE: begin
                if (!halt && tx) begin
                    if (req_nil) begin
                        txc_d = 1'b1;
                    end else begin
                        data_d   = out_data;
                        any_d    = req_any;
                        tgt_d    = req_tgt;
                        ovalid_d = req_any ? onehot(rr_q) : onehot(req_tgt);
                        state_d  = SEND;
                    end
                end else if (!halt && rx) begin
                    if (req_nil) begin
                        in_data_d = '0;
                        rxc_d     = 1'b1;
                    end else begin
                        any_d   = req_any;
                        tgt_d   = req_tgt;
                        state_d = RECV;
                    end
                end
            end
            SEND: begin
                if (any_q) rr_d = rr_next(rr_q);
                if (tx_hit) begin
                    ovalid_d = '0;
                    txc_d    = 1'b1;
                    state_d  = IDLE;
                    if (any_q) begin
                        last_dir_d   = idx_of(ovalid_q);
                        last_valid_d = 1'b1;
                    end
                end else if (halt) begin
                    ovalid_d = '0;
                    state_d  = IDLE;
                end else if (any_q) begin
                    ovalid_d = onehot(rr_next(rr_q));
                end
            end
            RECV: begin
                if (rx_hit) begin
                    in_data_d = rx_word;
                    rxc_d     = 1'b1;
                    state_d   = IDLE;
                    if (any_q) begin
                        last_dir_d   = idx_of(rx_sel);
                        last_valid_d = 1'b1;
                    end
                end else if (halt) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            data_q       <= '0;
            in_data_q    <= '0;
            txc_q        <= 1'b0;
            rxc_q        <= 1'b0;
            any_q        <= 1'b0;
            tgt_q        <= '0;
            last_dir_q   <= '0;
            last_valid_q <= 1'b0;
            rr_q         <= '0;
            ovalid_q     <= '0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            in_data_q    <= in_data_d;
            txc_q        <= txc_d;
            rxc_q        <= rxc_d;
            any_q        <= any_d;
            tgt_q        <= tgt_d;
            last_dir_q   <= last_dir_d;
            last_valid_q <= last_valid_d;
            rr_q         <= rr_d;
            ovalid_q     <= ovalid_d;
        end
    end

    assign in_data        = in_data_q;
    assign tx_complete    = txc_q;
    assign rx_complete    = rxc_q;
    assign busy           = (state_q != IDLE);
    assign last_dir       = last_dir_q;
    assign port_out_valid = ovalid_q;
    assign port_out_data  = {NPORTS{data_q}};

endmodule

// File: tb/tb_node_port_mux.sv
// Randomized self-checking bench for node_port_mux against a
// transaction-level model of direction resolution and ANY rotation.
module tb_node_port_mux;

    localparam int N  = 4;
    localparam int W  = 11;
    localparam int DW = 3;
    localparam int D_ANY  = 4;
    localparam int D_LAST = 5;
    localparam int D_NIL  = 6;

    logic          CLK;
    logic          nRST;
    logic          tx;
    logic          rx;
    logic [DW-1:0] dir;
    logic          halt;
    logic [W-1:0]  out_data;
    logic [W-1:0]  in_data;
    logic          tx_complete;
    logic          rx_complete;
    logic          busy;
    logic [DW-1:0] last_dir;
    logic [N-1:0]  port_out_valid;
    logic [N*W-1:0] port_out_data;
    logic [N-1:0]  port_out_ack;
    logic [N-1:0]  port_in_valid;
    logic [N*W-1:0] port_in_data;
    logic [N-1:0]  port_in_ack;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int     rr_m  = 0;
    int     ld_m  = 0;
    bit     lv_m  = 0;
    logic [W-1:0] in_m = '0;

    node_port_mux #(
        .NPORTS(N),
        .WORD_W(W),
        .DIR_W(DW)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .tx(tx),
        .rx(rx),
        .dir(dir),
        .halt(halt),
        .out_data(out_data),
        .in_data(in_data),
        .tx_complete(tx_complete),
        .rx_complete(rx_complete),
        .busy(busy),
        .last_dir(last_dir),
        .port_out_valid(port_out_valid),
        .port_out_data(port_out_data),
        .port_out_ack(port_out_ack),
        .port_in_valid(port_in_valid),
        .port_in_data(port_in_data),
        .port_in_ack(port_in_ack)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [W-1:0] rand_word();
        int s;
        s = int'($urandom_range(1998)) - 999;
        return s[W-1:0];
    endfunction

    function automatic logic [N*W-1:0] rand_bus();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[N*W-1:0];
    endfunction

    function automatic bit is_nil(input int d);
        return (d == D_NIL) || (d == D_LAST && !lv_m);
    endfunction

    function automatic int resolve(input int d);
        return (d == D_LAST) ? ld_m : d;
    endfunction

    task automatic do_write(input int d, input logic [W-1:0] w,
                            input int wait_n);
        int t;
        logic [N-1:0] tm;
        t  = resolve(d);
        tm = N'(1) << t;
        tx = 1'b1;
        dir = DW'(d);
        out_data = w;
        tick();
        tx = 1'b0;
        out_data = rand_word();
        if (is_nil(d)) begin
            chk("wr_nil_txc", 64'(tx_complete), 64'd1);
            chk("wr_nil_busy", 64'(busy), 64'd0);
            chk("wr_nil_valid", 64'(port_out_valid), 64'd0);
            return;
        end
        chk("wr_busy", 64'(busy), 64'd1);
        chk("wr_pulse_once", 64'(tx_complete | rx_complete), 64'd0);
        for (int i = 0; i < wait_n; i++) begin
            chk("wr_wait_valid", 64'(port_out_valid), 64'(tm));
            port_out_ack = N'($urandom()) & ~tm;
            tick();
            chk("wr_wait_txc", 64'(tx_complete), 64'd0);
        end
        chk("wr_valid", 64'(port_out_valid), 64'(tm));
        chk("wr_data", 64'(port_out_data), 64'({N{w}}));
        port_out_ack = tm;
        tick();
        port_out_ack = '0;
        chk("wr_txc", 64'(tx_complete), 64'd1);
        chk("wr_valid_drop", 64'(port_out_valid), 64'd0);
        chk("wr_busy_drop", 64'(busy), 64'd0);
        chk("wr_last_dir", 64'(last_dir), 64'(ld_m));
    endtask

    task automatic do_write_any(input logic [W-1:0] w, input int p);
        bit done;
        done = 0;
        tx = 1'b1;
        dir = DW'(D_ANY);
        out_data = w;
        tick();
        tx = 1'b0;
        port_out_ack = N'(1) << p;
        for (int c = 0; c < 2 * N && !done; c++) begin
            chk("any_wr_offer", 64'(port_out_valid), 64'(N'(1) << rr_m));
            chk("any_wr_data", 64'(port_out_data), 64'({N{w}}));
            if (rr_m == p) begin
                tick();
                chk("any_wr_txc", 64'(tx_complete), 64'd1);
                chk("any_wr_valid_drop", 64'(port_out_valid), 64'd0);
                ld_m = p;
                lv_m = 1;
                chk("any_wr_last_dir", 64'(last_dir), 64'(ld_m));
                done = 1;
            end else begin
                tick();
                chk("any_wr_no_txc", 64'(tx_complete), 64'd0);
            end
            rr_m = (rr_m + 1) % N;
        end
        port_out_ack = '0;
        if (!done) chk("any_wr_bound", 64'd0, 64'd1);
    endtask

    task automatic do_read(input int d, input logic [W-1:0] w,
                           input int wait_n);
        int t;
        logic [N-1:0] tm;
        t  = resolve(d);
        tm = N'(1) << t;
        port_in_valid = '0;
        rx = 1'b1;
        dir = DW'(d);
        if (is_nil(d)) port_in_valid = '1;
        tick();
        rx = 1'b0;
        if (is_nil(d)) begin
            chk("rd_nil_ack", 64'(port_in_ack), 64'd0);
            port_in_valid = '0;
            in_m = '0;
            chk("rd_nil_rxc", 64'(rx_complete), 64'd1);
            chk("rd_nil_data", 64'(in_data), 64'(in_m));
            chk("rd_nil_busy", 64'(busy), 64'd0);
            return;
        end
        chk("rd_busy", 64'(busy), 64'd1);
        chk("rd_pulse_once", 64'(tx_complete | rx_complete), 64'd0);
        for (int i = 0; i < wait_n; i++) begin
            port_in_valid = N'($urandom()) & ~tm;
            port_in_data  = rand_bus();
            #1;
            chk("rd_wait_ack", 64'(port_in_ack), 64'd0);
            tick();
            chk("rd_wait_rxc", 64'(rx_complete), 64'd0);
        end
        port_in_valid = (N'($urandom()) & ~tm) | tm;
        port_in_data  = rand_bus();
        port_in_data[t*W +: W] = w;
        #1;
        chk("rd_ack", 64'(port_in_ack), 64'(tm));
        tick();
        port_in_valid = '0;
        in_m = w;
        chk("rd_rxc", 64'(rx_complete), 64'd1);
        chk("rd_data", 64'(in_data), 64'(in_m));
        chk("rd_busy_drop", 64'(busy), 64'd0);
        chk("rd_last_dir", 64'(last_dir), 64'(ld_m));
    endtask

    task automatic do_read_any(input logic [N-1:0] mask,
                               input logic [N*W-1:0] words,
                               input int wait_n);
        int p;
        p = 0;
        for (int i = N - 1; i >= 0; i--) if (mask[i]) p = i;
        port_in_valid = '0;
        rx = 1'b1;
        dir = DW'(D_ANY);
        tick();
        rx = 1'b0;
        chk("any_rd_busy", 64'(busy), 64'd1);
        for (int i = 0; i < wait_n; i++) begin
            #1;
            chk("any_rd_wait_ack", 64'(port_in_ack), 64'd0);
            tick();
        end
        port_in_valid = mask;
        port_in_data  = words;
        #1;
        chk("any_rd_ack", 64'(port_in_ack), 64'(N'(1) << p));
        tick();
        port_in_valid = '0;
        in_m = words[p*W +: W];
        ld_m = p;
        lv_m = 1;
        chk("any_rd_rxc", 64'(rx_complete), 64'd1);
        chk("any_rd_data", 64'(in_data), 64'(in_m));
        chk("any_rd_last_dir", 64'(last_dir), 64'(ld_m));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_txc"}, 64'(tx_complete), 64'd0);
        chk({tag, "_rxc"}, 64'(rx_complete), 64'd0);
        chk({tag, "_in_data"}, 64'(in_data), 64'd0);
        chk({tag, "_last_dir"}, 64'(last_dir), 64'd0);
        chk({tag, "_ovalid"}, 64'(port_out_valid), 64'd0);
        chk({tag, "_odata"}, 64'(port_out_data), 64'd0);
        chk({tag, "_iack"}, 64'(port_in_ack), 64'd0);
    endtask

    initial begin
        logic [N*W-1:0] bus;
        logic [W-1:0] w;
        nRST = 1'b0;
        tx = 1'b0;
        rx = 1'b0;
        dir = '0;
        halt = 1'b0;
        out_data = '0;
        port_out_ack = '0;
        port_in_valid = '0;
        port_in_data = '0;
        tick();
        tick();
        chk_all_zero("reset");
        nRST = 1'b1;
        tick();

        // Pseudo-directions straight after reset
        do_read(D_LAST, 11'd0, 0);
        do_write(D_NIL, 11'd123, 0);

        // Directed scenarios
        do_write(1, 11'd37, 5);
        bus = '0;
        w = 11'(-5);
        bus[2*W +: W] = w;
        bus[3*W +: W] = 11'd9;
        do_read_any(4'b1100, bus, 1);
        do_write(D_LAST, 11'd100, 2);
        do_write_any(11'd77, 3);

        // Halt in IDLE blocks acceptance
        halt = 1'b1;
        tx = 1'b1;
        dir = 3'd0;
        out_data = 11'd5;
        tick();
        tx = 1'b0;
        halt = 1'b0;
        chk("halt_idle_busy", 64'(busy), 64'd0);
        chk("halt_idle_valid", 64'(port_out_valid), 64'd0);
        chk("halt_idle_txc", 64'(tx_complete), 64'd0);

        // Halt while a DOWN read has no data
        rx = 1'b1;
        dir = 3'd3;
        tick();
        rx = 1'b0;
        repeat (3) begin
            #1;
            chk("halt_rd_wait_ack", 64'(port_in_ack), 64'd0);
            tick();
        end
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("halt_rd_busy", 64'(busy), 64'd0);
        chk("halt_rd_rxc", 64'(rx_complete), 64'd0);
        chk("halt_rd_data", 64'(in_data), 64'(in_m));
        chk("halt_rd_last_dir", 64'(last_dir), 64'(ld_m));
        tick();
        chk("halt_rd_rxc2", 64'(rx_complete), 64'd0);

        // Halt coinciding with a valid: the transfer completes
        rx = 1'b1;
        dir = 3'd3;
        tick();
        rx = 1'b0;
        tick();
        w = 11'd321;
        port_in_valid = 4'b1000;
        port_in_data = '0;
        port_in_data[3*W +: W] = w;
        halt = 1'b1;
        #1;
        chk("halt_ack_ack", 64'(port_in_ack), 64'(4'b1000));
        tick();
        halt = 1'b0;
        port_in_valid = '0;
        in_m = w;
        chk("halt_ack_rxc", 64'(rx_complete), 64'd1);
        chk("halt_ack_data", 64'(in_data), 64'(in_m));

        // Halt during a physical write
        tx = 1'b1;
        dir = 3'd0;
        out_data = 11'd44;
        tick();
        tx = 1'b0;
        chk("halt_wr_valid", 64'(port_out_valid), 64'(4'b0001));
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("halt_wr_valid_drop", 64'(port_out_valid), 64'd0);
        chk("halt_wr_txc", 64'(tx_complete), 64'd0);
        chk("halt_wr_busy", 64'(busy), 64'd0);

        // Asynchronous reset mid-SEND
        tx = 1'b1;
        dir = 3'd1;
        out_data = 11'd55;
        tick();
        tx = 1'b0;
        tick();
        chk("rst_pre_valid", 64'(port_out_valid), 64'(4'b0010));
        #2;
        nRST = 1'b0;
        #1;
        chk_all_zero("async_rst");
        rr_m = 0;
        ld_m = 0;
        lv_m = 0;
        in_m = '0;
        @(negedge CLK);
        nRST = 1'b1;
        tick();

        // Randomized transactions against the model
        for (int k = 0; k < 60; k++) begin
            int d;
            int wn;
            d  = int'($urandom_range(6));
            wn = int'($urandom_range(3));
            if ($urandom_range(1) == 0) begin
                if (d == D_ANY) do_write_any(rand_word(), int'($urandom_range(N - 1)));
                else do_write(d, rand_word(), wn);
            end else begin
                if (d == D_ANY) do_read_any(N'($urandom_range(15, 1)), rand_bus(), wn);
                else do_read(d, rand_word(), wn);
            end
            if ($urandom_range(1) == 0) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
